// File: rtl/writeback_register_file.sv
`default_nettype none
// ============================================================================
// Module   : writeback_register_file
// Brief    : 32x32 register file fed by the MEM/WB writeback stage, with a
//            commit counter. Optional same-cycle write-to-read bypass when
//            REGFILE_WRITE_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
module writeback_register_file #(
  parameter logic [31:0] RESET_VALUE = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_reg_write,
  input  logic        wb_mem_to_reg,
  input  logic [31:0] wb_data_memory,
  input  logic [31:0] wb_alu_result,
  input  logic [4:0]  wb_rt_rd,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] wb_write_data,
  output logic [31:0] wb_write_count
);

  // Register 0 is hardwired to zero, so only 1..31 are stored.
  logic [31:0] r_regs [1:31];
  logic [31:0] r_write_count;
  logic        w_commit;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  assign wb_write_data = wb_mem_to_reg ? wb_data_memory : wb_alu_result;
  assign w_commit      = wb_reg_write && (wb_rt_rd != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= RESET_VALUE;
      end
      r_write_count <= 32'd0;
    end else if (w_commit) begin
      r_regs[wb_rt_rd] <= wb_write_data;
      r_write_count    <= r_write_count + 32'd1;
    end
  end

  always_comb begin
    w_rs_data = 32'd0;
    w_rt_data = 32'd0;
    if (id_rs != 5'd0) begin
      w_rs_data = r_regs[id_rs];
    end
    if (id_rt != 5'd0) begin
      w_rt_data = r_regs[id_rt];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // w_commit already excludes index 0; reset gates bypass off during reset.
    if (w_commit && reset && (id_rs == wb_rt_rd)) begin
      w_rs_data = wb_write_data;
    end
    if (w_commit && reset && (id_rt == wb_rt_rd)) begin
      w_rt_data = wb_write_data;
    end
`else
`endif
  end

  assign id_rs_data     = w_rs_data;
  assign id_rt_data     = w_rt_data;
  assign wb_write_count = r_write_count;

endmodule
`default_nettype wire
